// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_pkg
//  Description : Constants, the data word type and a pointer-width helper
//                shared by the UART receive buffer.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_rx_pkg;

    localparam int UART_DATA_WIDTH = 8;
    localparam int RX_FIFO_DEPTH   = 8;

    typedef logic [UART_DATA_WIDTH-1:0] uart_data_t;

    // The extra MSB lets full and empty be told apart when the low bits match
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : uart_rx_pkg
`default_nettype wire

// File: rtl/uart_rx_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo_mem
//  Description : Simple dual-port register array, synchronous write and
//                asynchronous read. Contents are deliberately not reset.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0]    i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0]    o_rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Write port: store the incoming word on an accepted push
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    // Read port: head entry is visible without a clock (first-word fall-through)
    always_comb begin
        o_rdata = mem_q[i_raddr];
    end

endmodule : uart_rx_fifo_mem
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : FWFT receive buffer behind the UART RX deserializer. Pushes
//                on Data_Valid, pops on Rd_En, reports fill level and sticky
//                overflow/underflow flags.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DEPTH      = RX_FIFO_DEPTH,
    parameter int AF_LEVEL   = 6
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic [DATA_WIDTH-1:0]      P_DATA,
    input  logic                       Data_Valid,
    input  logic                       Rd_En,
    input  logic                       Clr_Flags,
    output logic [DATA_WIDTH-1:0]      Rd_Data,
    output logic                       Empty,
    output logic                       Full,
    output logic                       Almost_Full,
    output logic [$clog2(DEPTH):0]     Count,
    output logic                       Overflow,
    output logic                       Underflow
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int AW    = PTR_W - 1;
    localparam logic [PTR_W-1:0] C_AF_LEVEL = PTR_W'(AF_LEVEL);
    localparam logic [PTR_W-1:0] C_ONE      = PTR_W'(1);

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      count_q,  count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_ovf_evt;
    logic                  w_udf_evt;
    logic [DATA_WIDTH-1:0] w_rdata;

    uart_rx_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .i_clk   (Clk),
        .i_we    (w_push),
        .i_waddr (wr_ptr_q[AW-1:0]),
        .i_wdata (P_DATA),
        .i_raddr (rd_ptr_q[AW-1:0]),
        .o_rdata (w_rdata)
    );

    // Status from registered pointers only; a pop while full frees a slot for a push
    always_comb begin
        w_empty   = (wr_ptr_q == rd_ptr_q);
        w_full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                    (wr_ptr_q[AW] != rd_ptr_q[AW]);
        w_pop     = Rd_En & ~w_empty;
        w_push    = Data_Valid & (~w_full | w_pop);
        w_ovf_evt = Data_Valid & w_full & ~w_pop;
        w_udf_evt = Rd_En & w_empty;
    end

    // Next-state: pointers, occupancy and sticky flags (a new event beats a clear)
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + C_ONE;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + C_ONE;
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + C_ONE;
            2'b01:   count_d = count_q - C_ONE;
            default: count_d = count_q;
        endcase

        if (Clr_Flags) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (w_ovf_evt) begin
            overflow_d = 1'b1;
        end
        if (w_udf_evt) begin
            underflow_d = 1'b1;
        end
    end

    // State register; reset drops every entry and overrides all other inputs
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Output mapping; read data is forced to zero while nothing is stored
    always_comb begin
        Rd_Data     = w_empty ? '0 : w_rdata;
        Empty       = w_empty;
        Full        = w_full;
        Count       = count_q;
        Almost_Full = (count_q >= C_AF_LEVEL);
        Overflow    = overflow_q;
        Underflow   = underflow_q;
    end

endmodule : uart_rx_fifo
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Directed self-checking bench for uart_rx_fifo with a
//                scoreboard queue of expected read data.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_fifo;
    import uart_rx_pkg::*;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    uart_data_t P_DATA = '0;
    logic       Data_Valid = 1'b0;
    logic       Rd_En = 1'b0;
    logic       Clr_Flags = 1'b0;
    uart_data_t Rd_Data;
    logic       Empty, Full, Almost_Full, Overflow, Underflow;
    logic [3:0] Count;

    int total = 0;
    int bad   = 0;
    uart_data_t sb[$];

    uart_rx_fifo #(
        .DATA_WIDTH (8),
        .DEPTH      (8),
        .AF_LEVEL   (6)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .P_DATA      (P_DATA),
        .Data_Valid  (Data_Valid),
        .Rd_En       (Rd_En),
        .Clr_Flags   (Clr_Flags),
        .Rd_Data     (Rd_Data),
        .Empty       (Empty),
        .Full        (Full),
        .Almost_Full (Almost_Full),
        .Count       (Count),
        .Overflow    (Overflow),
        .Underflow   (Underflow)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input uart_data_t b, input bit accept);
        P_DATA = b;
        Data_Valid = 1'b1;
        if (accept) sb.push_back(b);
        cyc();
        Data_Valid = 1'b0;
    endtask

    task automatic pop(input string tag);
        uart_data_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk(tag, Rd_Data, e);
        end
        Rd_En = 1'b1;
        cyc();
        Rd_En = 1'b0;
    endtask

    task automatic pushpop(input uart_data_t b, input string tag);
        uart_data_t e;
        e = sb.pop_front();
        chk(tag, Rd_Data, e);
        sb.push_back(b);
        P_DATA = b;
        Data_Valid = 1'b1;
        Rd_En = 1'b1;
        cyc();
        Data_Valid = 1'b0;
        Rd_En = 1'b0;
    endtask

    initial begin
        // 1: reset state
        Rst = 1'b1;
        cyc();
        cyc();
        Rst = 1'b0;
        cyc();
        chk("rst_empty", Empty, 1);
        chk("rst_full", Full, 0);
        chk("rst_count", Count, 0);
        chk("rst_af", Almost_Full, 0);
        chk("rst_ovf", Overflow, 0);
        chk("rst_udf", Underflow, 0);
        chk("rst_rdata", Rd_Data, 0);

        // 2: three pushes, FWFT latency, ordered drain
        push(8'hA5, 1);
        chk("fwft_empty", Empty, 0);
        chk("fwft_rdata", Rd_Data, 8'hA5);
        push(8'h3C, 1);
        push(8'hFF, 1);
        chk("three_count", Count, 3);
        pop("drain3_0");
        pop("drain3_1");
        pop("drain3_2");
        chk("drain3_empty", Empty, 1);
        chk("drain3_count", Count, 0);

        // 3: fill, almost-full threshold, overflow, clear
        for (int i = 0; i < 8; i++) begin
            push(uart_data_t'(i), 1);
            chk($sformatf("fill_count_%0d", i), Count, i + 1);
            chk($sformatf("fill_af_%0d", i), Almost_Full, (i + 1 >= 6) ? 1 : 0);
            chk($sformatf("fill_full_%0d", i), Full, (i + 1 == 8) ? 1 : 0);
        end
        push(8'h08, 0);
        chk("ovf_flag", Overflow, 1);
        chk("ovf_count", Count, 8);
        chk("ovf_rdata", Rd_Data, 8'h00);
        Clr_Flags = 1'b1;
        cyc();
        Clr_Flags = 1'b0;
        chk("ovf_clear", Overflow, 0);

        // 4: push and pop together while full
        pushpop(8'h55, "fullpp_head");
        chk("fullpp_count", Count, 8);
        chk("fullpp_full", Full, 1);
        chk("fullpp_ovf", Overflow, 0);
        for (int i = 0; i < 8; i++) begin
            pop($sformatf("fulldrain_%0d", i));
        end
        chk("fulldrain_empty", Empty, 1);

        // 5: underflow behaviour
        Rd_En = 1'b1;
        cyc();
        Rd_En = 1'b0;
        chk("udf_flag", Underflow, 1);
        chk("udf_count", Count, 0);
        chk("udf_empty", Empty, 1);
        Clr_Flags = 1'b1;
        cyc();
        Clr_Flags = 1'b0;
        chk("udf_clear", Underflow, 0);
        P_DATA = 8'h99;
        Data_Valid = 1'b1;
        Rd_En = 1'b1;
        sb.push_back(8'h99);
        cyc();
        Data_Valid = 1'b0;
        Rd_En = 1'b0;
        chk("udfpp_count", Count, 1);
        chk("udfpp_rdata", Rd_Data, 8'h99);
        chk("udfpp_flag", Underflow, 1);
        pop("udfpp_pop");
        Clr_Flags = 1'b1;
        Rd_En = 1'b1;
        cyc();
        Clr_Flags = 1'b0;
        Rd_En = 1'b0;
        chk("udf_set_wins", Underflow, 1);

        // 6: pointer wrap with a streaming push/pop pattern, then reset mid-use
        push(8'h80, 1);
        push(8'h81, 1);
        for (int i = 0; i < 20; i++) begin
            pushpop(uart_data_t'(8'h82 + i), $sformatf("wrap_%0d", i));
            chk($sformatf("wrap_count_%0d", i), Count, 2);
        end
        push(8'hC0, 1);
        push(8'hC1, 1);
        push(8'hC2, 1);
        chk("prerst_count", Count, 5);
        chk("prerst_head", Rd_Data, sb[0]);
        Rst = 1'b1;
        P_DATA = 8'hEE;
        Data_Valid = 1'b1;
        cyc();
        Rst = 1'b0;
        Data_Valid = 1'b0;
        sb.delete();
        chk("midrst_count", Count, 0);
        chk("midrst_empty", Empty, 1);
        chk("midrst_rdata", Rd_Data, 0);
        chk("midrst_udf", Underflow, 0);
        push(8'h12, 1);
        chk("postrst_count", Count, 1);
        pop("postrst_pop");
        chk("postrst_empty", Empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_uart_rx_fifo
`default_nettype wire
